conv_engine_cu: RTL and testbench

//  Convolution engine controller + MAC, downstream of the memory reader stage. On start (reader's done pulse),

---
 rtl/conv_engine_cu.sv | 183 ++++++++++++++++++
 tb/tb_conv_engine_cu.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/conv_engine_cu.sv
// Convolution engine control unit with MAC datapath.
// Reads pre-loaded filter and image buffers, computes valid stride-1 2-D
// convolutions (filter outer, row middle, column inner) and streams one
// signed result per output pixel over a valid/ready port.
// Optional build macro: RELU_EN clamps negative results to zero.
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | waiting for start, busy low
// S_INIT  | one cycle: clear counters/accumulator, issue tap-0 address
// S_MAC   | KK+1 cycles: issue tap addresses, accumulate products
// S_OUT   | result presented, waiting for out_ready handshake
// S_DONE  | one cycle: done pulse, then back to idle

module conv_engine_cu #(
   parameter int IMG_SIZE    = 16,
   parameter int FILT_SIZE   = 2,
   parameter int NUM_FILTERS = 4,
   parameter int ACC_W       = 20
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   output logic [7:0]       filt_rd_adr,
   input  logic [7:0]       filt_rd_data,
   output logic [15:0]      img_rd_adr,
   input  logic [7:0]       img_rd_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [ACC_W-1:0] out_data,
   output logic [7:0]       out_filter,
   output logic [7:0]       out_row,
   output logic [7:0]       out_col,
   output logic             busy,
   output logic             done
);

   localparam int KK       = FILT_SIZE * FILT_SIZE;
   localparam int OUT_SIZE = IMG_SIZE - FILT_SIZE + 1;
   localparam int TW       = $clog2(KK + 1);

   localparam logic [TW-1:0] T_LAST_ADR = TW'(KK - 1);
   localparam logic [TW-1:0] T_END      = TW'(KK);
   localparam logic [7:0]    C_MAX      = 8'(OUT_SIZE - 1);
   localparam logic [7:0]    F_MAX      = 8'(NUM_FILTERS - 1);
   localparam logic [7:0]    K_MAX      = 8'(FILT_SIZE - 1);

   typedef enum logic [2:0] {S_IDLE, S_INIT, S_MAC, S_OUT, S_DONE} state_t;

   state_t                  state;
   logic [7:0]              f, r, c;
   logic [TW-1:0]           t;
   logic [7:0]              ar, ac;
   logic signed [ACC_W-1:0] acc;

   logic                    c_last, r_last, last;
   logic [7:0]              c_n, r_n, f_n;
   logic [7:0]              ar_n, ac_n;
   logic signed [16:0]      prod;
   logic signed [ACC_W-1:0] acc_sum;
   logic [ACC_W-1:0]        res;

   function automatic logic [7:0] filt_adr_of(input logic [7:0] fi, input logic [7:0] tr,
                                              input logic [7:0] tc);
      return fi * 8'(KK) + tr * 8'(FILT_SIZE) + tc;
   endfunction

   function automatic logic [15:0] img_adr_of(input logic [7:0] ri, input logic [7:0] ci,
                                              input logic [7:0] tr, input logic [7:0] tc);
      return ({8'd0, ri} + {8'd0, tr}) * 16'(IMG_SIZE) + {8'd0, ci} + {8'd0, tc};
   endfunction

   // Next output position, next tap position, and the MAC datapath.
   always_comb begin
      c_last  = (c == C_MAX);
      r_last  = (r == C_MAX);
      last    = c_last && r_last && (f == F_MAX);
      c_n     = c_last ? 8'd0 : c + 8'd1;
      r_n     = c_last ? (r_last ? 8'd0 : r + 8'd1) : r;
      f_n     = (c_last && r_last) ? f + 8'd1 : f;
      ac_n    = (ac == K_MAX) ? 8'd0 : ac + 8'd1;
      ar_n    = (ac == K_MAX) ? ar + 8'd1 : ar;
      // weight is signed, pixel is zero-extended; the 17-bit product cannot overflow
      prod    = $signed({{9{filt_rd_data[7]}}, filt_rd_data}) * $signed({9'd0, img_rd_data});
      acc_sum = acc + {{(ACC_W-17){prod[16]}}, prod};
`ifdef RELU_EN
      res     = acc_sum[ACC_W-1] ? '0 : acc_sum;
`else
      res     = acc_sum;
`endif
   end

   // Sequencer: state, counters, accumulator and all registered outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= S_IDLE;
         f           <= '0;
         r           <= '0;
         c           <= '0;
         t           <= '0;
         ar          <= '0;
         ac          <= '0;
         acc         <= '0;
         filt_rd_adr <= '0;
         img_rd_adr  <= '0;
         out_valid   <= 1'b0;
         out_data    <= '0;
         out_filter  <= '0;
         out_row     <= '0;
         out_col     <= '0;
         busy        <= 1'b0;
         done        <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               done <= 1'b0;
               if (start) begin
                  busy  <= 1'b1;
                  state <= S_INIT;
               end
            end
            S_INIT: begin
               f           <= '0;
               r           <= '0;
               c           <= '0;
               t           <= '0;
               ar          <= '0;
               ac          <= '0;
               acc         <= '0;
               filt_rd_adr <= filt_adr_of(8'd0, 8'd0, 8'd0);
               img_rd_adr  <= img_adr_of(8'd0, 8'd0, 8'd0, 8'd0);
               state       <= S_MAC;
            end
            S_MAC: begin
               t <= t + TW'(1);
               // read data lags the address by one cycle, so cycle 0 has nothing to add
               if (t != '0) acc <= acc_sum;
               if (t < T_LAST_ADR) begin
                  ar          <= ar_n;
                  ac          <= ac_n;
                  filt_rd_adr <= filt_adr_of(f, ar_n, ac_n);
                  img_rd_adr  <= img_adr_of(r, c, ar_n, ac_n);
               end
               if (t == T_END) begin
                  out_data   <= res;
                  out_filter <= f;
                  out_row    <= r;
                  out_col    <= c;
                  out_valid  <= 1'b1;
                  state      <= S_OUT;
               end
            end
            S_OUT: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  if (last) begin
                     done  <= 1'b1;
                     state <= S_DONE;
                  end else begin
                     f           <= f_n;
                     r           <= r_n;
                     c           <= c_n;
                     t           <= '0;
                     ar          <= '0;
                     ac          <= '0;
                     acc         <= '0;
                     filt_rd_adr <= filt_adr_of(f_n, 8'd0, 8'd0);
                     img_rd_adr  <= img_adr_of(r_n, c_n, 8'd0, 8'd0);
                     state       <= S_MAC;
                  end
               end
            end
            S_DONE: begin
               done  <= 1'b0;
               busy  <= 1'b0;
               state <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_conv_engine_cu.sv
// Testbench for conv_engine_cu: buffer models, a loop-based convolution
// reference queue, and a negedge monitor checking results, tap addresses,
// stall holding, latency and the done/busy handshake.

module tb_conv_engine_cu;

   localparam int IMG = 16;
   localparam int K   = 2;
   localparam int KK  = K * K;
   localparam int NF  = 4;
   localparam int AW  = 20;
   localparam int OS  = IMG - K + 1;
   localparam int TOTAL = NF * OS * OS;

   logic          clk = 1'b0;
   logic          rst;
   logic          start;
   logic [7:0]    filt_rd_adr;
   logic [7:0]    filt_rd_data;
   logic [15:0]   img_rd_adr;
   logic [7:0]    img_rd_data;
   logic          out_valid;
   logic          out_ready;
   logic [AW-1:0] out_data;
   logic [7:0]    out_filter, out_row, out_col;
   logic          busy, done;

   conv_engine_cu #(.IMG_SIZE(IMG), .FILT_SIZE(K), .NUM_FILTERS(NF), .ACC_W(AW)) dut (
      .clk(clk), .rst(rst), .start(start),
      .filt_rd_adr(filt_rd_adr), .filt_rd_data(filt_rd_data),
      .img_rd_adr(img_rd_adr), .img_rd_data(img_rd_data),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .out_filter(out_filter), .out_row(out_row), .out_col(out_col),
      .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   logic [7:0] filt_mem [0:255];
   logic [7:0] img_mem  [0:65535];

   // synchronous-read buffers: data one cycle after address
   always @(posedge clk) begin
      filt_rd_data <= filt_mem[filt_rd_adr];
      img_rd_data  <= img_mem[img_rd_adr];
   end

   typedef struct {
      logic [AW-1:0] d;
      int            f, r, c;
   } res_t;

   res_t exp_q[$];

   int checks = 0;
   int failures = 0;
   int n_res, n_done;
   int rdy_mode = 0;
   int stall = 0;
   bit forced = 0;
   bit start_acc = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
      end
   endtask

   task automatic load(input int kind);
      for (int i = 0; i < NF * KK; i++) begin
         case (kind)
            0: filt_mem[i] = 8'd1;
            1: filt_mem[i] = (i < KK) ? ((i == 0) ? 8'd1 : 8'd0) : 8'($urandom_range(0, 255));
            2: filt_mem[i] = 8'h80;
            default: filt_mem[i] = 8'($urandom_range(0, 255));
         endcase
      end
      for (int i = 0; i < IMG * IMG; i++) begin
         case (kind)
            0: img_mem[i] = 8'd1;
            1: img_mem[i] = 8'(i % 256);
            2: img_mem[i] = 8'd255;
            default: img_mem[i] = 8'($urandom_range(0, 255));
         endcase
      end
   endtask

   task automatic build_model();
      res_t e;
      logic [31:0] a;
      exp_q.delete();
      for (int f = 0; f < NF; f++)
         for (int r = 0; r < OS; r++)
            for (int c = 0; c < OS; c++) begin
               int acc = 0;
               for (int kr = 0; kr < K; kr++)
                  for (int kc = 0; kc < K; kc++)
                     acc += int'($signed(filt_mem[f*KK + kr*K + kc])) *
                            int'(img_mem[(r+kr)*IMG + c + kc]);
`ifdef RELU_EN
               if (acc < 0) acc = 0;
`endif
               a = acc;
               e.d = a[AW-1:0];
               e.f = f; e.r = r; e.c = c;
               exp_q.push_back(e);
            end
   endtask

   task automatic new_run(input int mode);
      n_res = 0; n_done = 0; forced = 0; stall = 0; rdy_mode = mode;
   endtask

   task automatic pulse_start(input bit accept);
      @(posedge clk); #1;
      start = 1'b1; start_acc = accept;
      @(posedge clk); #1;
      start = 1'b0; start_acc = 1'b0;
   endtask

   task automatic wait_done();
      for (int i = 0; i < 30000 && n_done == 0; i++) @(posedge clk);
      if (n_done == 0) check("done_timeout", 0, 1);
      repeat (4) @(posedge clk);
      check("result_count", n_res, TOTAL);
      check("done_count", n_done, 1);
      check("queue_empty", exp_q.size(), 0);
   endtask

   // consumer: always ready, or random stalls plus one forced 5-cycle stall
   initial begin
      out_ready = 1'b1;
      forever begin
         @(posedge clk); #1;
         if (rdy_mode == 0) out_ready = 1'b1;
         else if (out_valid && !forced && n_res >= 3) begin
            forced = 1; stall = 4; out_ready = 1'b0;
         end else if (stall > 0) begin
            out_ready = 1'b0; stall--;
         end else begin
            out_ready = 1'b1;
            if ($urandom_range(0, 7) == 0) stall = $urandom_range(1, 5);
         end
      end
   end

   // monitor
   initial begin
      int cyc = 0, last_evt = 0, exp_gap = 0, tap_idx = 0;
      bit tap_on = 0, busy_chk = 0, prev_valid = 0, prev_ready = 0;
      logic [AW-1:0] prev_data = '0;
      logic [23:0] prev_idx = '0, prev_adr = '0;
      res_t e;
      forever begin
         @(negedge clk);
         cyc++;
         if (rst) begin
            tap_on = 0; busy_chk = 0; prev_valid = 0; prev_ready = 0;
         end else begin
            if (tap_on && tap_idx >= 0 && tap_idx < KK && exp_q.size() > 0) begin
               check("filt_adr", 32'(filt_rd_adr), 32'(exp_q[0].f*KK + tap_idx));
               check("img_adr", 32'(img_rd_adr),
                     32'((exp_q[0].r + tap_idx/K)*IMG + exp_q[0].c + tap_idx%K));
            end
            if (tap_on) begin
               tap_idx++;
               if (tap_idx >= KK) tap_on = 0;
            end
            if (prev_valid && !prev_ready) begin
               check("valid_hold", 32'(out_valid), 1);
               check("data_hold", 32'(out_data), 32'(prev_data));
               check("idx_hold", 32'({out_filter, out_row, out_col}), 32'(prev_idx));
               check("adr_hold", 32'({filt_rd_adr, img_rd_adr}), 32'(prev_adr));
            end
            if (out_valid && !prev_valid) check("latency", cyc - last_evt, exp_gap);
            if (out_valid && out_ready) begin
               if (exp_q.size() == 0) check("extra_result", 1, 0);
               else begin
                  e = exp_q.pop_front();
                  check("out_data", 32'(out_data), 32'(e.d));
                  check("out_filter", 32'(out_filter), e.f);
                  check("out_row", 32'(out_row), e.r);
                  check("out_col", 32'(out_col), e.c);
                  n_res++;
                  last_evt = cyc; exp_gap = KK + 2;
                  if (exp_q.size() > 0) begin tap_on = 1; tap_idx = 0; end
               end
            end
            if (start_acc) begin
               last_evt = cyc; exp_gap = KK + 3; tap_on = 1; tap_idx = -1;
            end
            if (busy_chk) begin
               check("busy_after_done", 32'({busy, done}), 0);
               busy_chk = 0;
            end
            if (done) begin n_done++; busy_chk = 1; end
            prev_valid = out_valid; prev_ready = out_ready; prev_data = out_data;
            prev_idx = {out_filter, out_row, out_col};
            prev_adr = {filt_rd_adr, img_rd_adr};
         end
      end
   end

   task automatic check_idle_outputs(input string tag);
      check({tag, "_valid"}, 32'(out_valid), 0);
      check({tag, "_busy"}, 32'(busy), 0);
      check({tag, "_done"}, 32'(done), 0);
      check({tag, "_data"}, 32'(out_data), 0);
      check({tag, "_idx"}, 32'({out_filter, out_row, out_col}), 0);
   endtask

   initial begin
      rst = 1'b1; start = 1'b0;
      repeat (3) @(posedge clk); #1;
      check_idle_outputs("reset");
      check("reset_adr", 32'({filt_rd_adr, img_rd_adr}), 0);
      rst = 1'b0;

      // all ones, always ready
      load(0); build_model(); new_run(0); pulse_start(1); wait_done();
      // identity filter 0 over ramp image, stalling consumer
      load(1); build_model(); new_run(1); pulse_start(1); wait_done();
      // extreme negative products
      load(2); build_model(); new_run(0); pulse_start(1); wait_done();

      // abort during MAC of result 10, then restart with fresh data
      load(3); build_model(); new_run(1); pulse_start(1);
      for (int i = 0; i < 20000 && n_res < 10; i++) @(posedge clk);
      check("abort_reached", n_res, 10);
      repeat (2) @(posedge clk); #1;
      rst = 1'b1; #1;
      check_idle_outputs("abort");
      @(posedge clk); #1;
      rst = 1'b0;
      load(3); build_model(); new_run(1); pulse_start(1); wait_done();

      // second start while busy is ignored
      load(3); build_model(); new_run(0); pulse_start(1);
      repeat (20) @(posedge clk);
      pulse_start(0);
      wait_done();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
